// File: rtl/column_buffer_pkg.sv
// rtl/column_buffer_pkg.sv - shared constants and FSM state type for the column buffer
package column_buffer_pkg;

    localparam int WORDS_PER_COLUMN = 768;  // 16 LEDs x 48 bits
    localparam int NB_DRIVERS       = 30;
    localparam int ADDR_W           = 10;
    localparam int RAM_ADDR_W       = ADDR_W + 1;  // bank bit on top of the word index

    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(WORDS_PER_COLUMN - 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREFETCH = 2'd1,
        ST_STREAM   = 2'd2
    } state_t;

endpackage

// File: rtl/column_ram.sv
// rtl/column_ram.sv - simple dual-port 1536 x 30 RAM, registered read, bank bit as address MSB
//
// Ports:
//   clk    - clock
//   we     - write enable
//   waddr  - {bank, word} write address
//   wdata  - write data
//   raddr  - {bank, word} read address
//   rdata  - read data, one cycle after raddr
module column_ram
    import column_buffer_pkg::*;
(
    input  logic                  clk,
    input  logic                  we,
    input  logic [RAM_ADDR_W-1:0] waddr,
    input  logic [NB_DRIVERS-1:0] wdata,
    input  logic [RAM_ADDR_W-1:0] raddr,
    output logic [NB_DRIVERS-1:0] rdata
);

    localparam int DEPTH = 2 * WORDS_PER_COLUMN;

    logic [NB_DRIVERS-1:0] mem [DEPTH];

    // Bank 1 lives directly after bank 0 so the array is exactly two columns deep.
    function automatic logic [RAM_ADDR_W-1:0] flat(input logic [RAM_ADDR_W-1:0] a);
        logic [RAM_ADDR_W-1:0] word;
        word = {1'b0, a[ADDR_W-1:0]};
        return a[ADDR_W] ? (word + RAM_ADDR_W'(WORDS_PER_COLUMN)) : word;
    endfunction

    always_ff @(posedge clk) begin
        if (we) begin
            mem[flat(waddr)] <= wdata;
        end
        rdata <= mem[flat(raddr)];
    end

endmodule

// File: rtl/column_buffer.sv
// rtl/column_buffer.sv - double-buffered column store streaming serial slots to the driver controller
//
// Ports:
//   clk, nrst        - clock, asynchronous active-low reset
//   clk_enable       - serial-slot strobe; one word consumed per high cycle while streaming
//   wr_en/wr_addr/wr_dat - write port into the back bank (addresses above 767 dropped)
//   wr_commit        - back bank complete; swapped in at the next column_ready
//   wr_ready         - no commit is pending
//   column_ready     - driver controller requests the next column
//   framebuffer_dat  - current serial slot, zero when not streaming
//   position_sync    - pulse in the cycle the banks swap
//   stream_done      - pulse in the cycle after the last word is consumed
//   err_overrun      - sticky: commit while pending, or column_ready while busy
module column_buffer
    import column_buffer_pkg::*;
(
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  clk_enable,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [NB_DRIVERS-1:0] wr_dat,
    input  logic                  wr_commit,
    output logic                  wr_ready,
    input  logic                  column_ready,
    output logic [NB_DRIVERS-1:0] framebuffer_dat,
    output logic                  position_sync,
    output logic                  stream_done,
    output logic                  err_overrun
);

    state_t                state, state_nxt;
    logic                  front_bank;
    logic                  commit_pending;
    logic [ADDR_W-1:0]     rd_cnt;
    logic [ADDR_W-1:0]     rd_word;
    logic                  stream_done_q;
    logic                  err_q;
    logic                  swap;
    logic                  consume;
    logic                  last;
    logic                  col_err;
    logic                  ram_we;
    logic [NB_DRIVERS-1:0] ram_q;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // rd_word is the address presented to the RAM this cycle. While streaming it
    // already points at the word to be shown next cycle, which hides the RAM
    // read latency and lets a new word appear on every clk_enable cycle.
    always_comb begin
        state_nxt = state;
        swap      = 1'b0;
        consume   = 1'b0;
        last      = 1'b0;
        col_err   = 1'b0;
        rd_word   = rd_cnt;
        case (state)
            ST_IDLE: begin
                if (column_ready) begin
                    // A commit arriving in this same cycle still counts.
                    swap      = commit_pending | wr_commit;
                    state_nxt = ST_PREFETCH;
                end
            end
            ST_PREFETCH: begin
                rd_word   = '0;
                col_err   = column_ready;
                state_nxt = ST_STREAM;
            end
            ST_STREAM: begin
                col_err = column_ready;
                if (clk_enable) begin
                    consume = 1'b1;
                    if (rd_cnt == LAST_WORD) begin
                        last      = 1'b1;
                        state_nxt = ST_IDLE;
                    end else begin
                        rd_word = rd_cnt + 1'b1;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            front_bank     <= 1'b0;
            commit_pending <= 1'b0;
            rd_cnt         <= '0;
            stream_done_q  <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            front_bank     <= front_bank ^ swap;
            commit_pending <= swap ? 1'b0 : (commit_pending | wr_commit);
            stream_done_q  <= last;
            err_q          <= err_q | col_err | (wr_commit & commit_pending);
            if (state == ST_PREFETCH || last) begin
                rd_cnt <= '0;
            end else if (consume) begin
                rd_cnt <= rd_cnt + 1'b1;
            end
        end
    end

    assign ram_we = wr_en && (wr_addr <= LAST_WORD);

    column_ram u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr ({~front_bank, wr_addr}),
        .wdata (wr_dat),
        .raddr ({front_bank, rd_word}),
        .rdata (ram_q)
    );

    assign framebuffer_dat = (state == ST_STREAM) ? ram_q : '0;
    assign wr_ready        = ~commit_pending;
    assign position_sync   = swap;
    assign stream_done     = stream_done_q;
    assign err_overrun     = err_q;

endmodule

// File: tb/tb_column_buffer.sv
// tb/tb_column_buffer.sv - self-checking bench for column_buffer
module tb_column_buffer;

    localparam int NW = 768;

    logic        clk = 1'b0;
    logic        nrst;
    logic        clk_enable;
    logic        wr_en;
    logic [9:0]  wr_addr;
    logic [29:0] wr_dat;
    logic        wr_commit;
    logic        wr_ready;
    logic        column_ready;
    logic [29:0] framebuffer_dat;
    logic        position_sync;
    logic        stream_done;
    logic        err_overrun;

    int tests = 0;
    int fails = 0;

    // Reference: two banks of words, which one is shown, commit/err flags.
    logic [29:0] mdl [2][NW];
    bit          mfront;
    bit          mpending;
    bit          merr;

    always #5 clk = ~clk;

    column_buffer dut (
        .clk            (clk),
        .nrst           (nrst),
        .clk_enable     (clk_enable),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_dat         (wr_dat),
        .wr_commit      (wr_commit),
        .wr_ready       (wr_ready),
        .column_ready   (column_ready),
        .framebuffer_dat(framebuffer_dat),
        .position_sync  (position_sync),
        .stream_done    (stream_done),
        .err_overrun    (err_overrun)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [9:0] a, input logic [29:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_dat  = d;
        if (a < NW) mdl[~mfront][a] = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic write_bank(input bit rnd);
        for (int k = 0; k < NW; k++) begin
            write_word(10'(k), rnd ? 30'($urandom) : 30'(k));
        end
    endtask

    task automatic commit();
        wr_commit = 1'b1;
        if (mpending) merr = 1'b1;
        mpending = 1'b1;
        step();
        wr_commit = 1'b0;
    endtask

    // One column request; period = cycles per clk_enable pulse, ov_at = word index
    // at which a stray column_ready is sent, rst_at = word index at which reset hits.
    task automatic run_column(input int period, input bit with_commit,
                              input int ov_at, input int rst_at);
        bit swap;
        bit ov;
        bit ov_done;
        int k;
        int cyc;
        column_ready = 1'b1;
        wr_commit    = with_commit;
        @(negedge clk);
        if (with_commit) begin
            if (mpending) merr = 1'b1;
            mpending = 1'b1;
        end
        swap = mpending;
        chk("position_sync_at_request", {31'b0, position_sync}, {31'b0, swap});
        if (swap) begin
            mfront   = ~mfront;
            mpending = 1'b0;
        end
        step();
        column_ready = 1'b0;
        wr_commit    = 1'b0;
        @(negedge clk);
        chk("prefetch_dat_zero", {2'b0, framebuffer_dat}, 32'h0);
        step();
        k       = 0;
        cyc     = 0;
        ov_done = 1'b0;
        while (k < NW) begin
            clk_enable = ((cyc % period) == (period - 1));
            ov = (k == ov_at) && !ov_done;
            if (ov) ov_done = 1'b1;
            column_ready = ov;
            if (k == rst_at) begin
                nrst = 1'b0;
                #1;
                chk("reset_dat_zero", {2'b0, framebuffer_dat}, 32'h0);
                chk("reset_no_done", {31'b0, stream_done}, 32'h0);
                step();
                nrst       = 1'b1;
                clk_enable = 1'b0;
                mfront     = 1'b0;
                mpending   = 1'b0;
                merr       = 1'b0;
                @(negedge clk);
                chk("after_reset_dat", {2'b0, framebuffer_dat}, 32'h0);
                chk("after_reset_no_done", {31'b0, stream_done}, 32'h0);
                chk("after_reset_err", {31'b0, err_overrun}, 32'h0);
                chk("after_reset_wr_ready", {31'b0, wr_ready}, 32'h1);
                step();
                return;
            end
            @(negedge clk);
            chk($sformatf("stream_dat_w%0d", k), {2'b0, framebuffer_dat}, {2'b0, mdl[mfront][k]});
            if (ov) begin
                merr = 1'b1;
                chk("no_sync_on_overrun", {31'b0, position_sync}, 32'h0);
            end
            step();
            column_ready = 1'b0;
            if (clk_enable) k++;
            cyc++;
        end
        clk_enable = 1'b0;
        @(negedge clk);
        chk("stream_done_pulse", {31'b0, stream_done}, 32'h1);
        chk("idle_dat_zero", {2'b0, framebuffer_dat}, 32'h0);
        chk("err_overrun_end", {31'b0, err_overrun}, {31'b0, merr});
        chk("wr_ready_end", {31'b0, wr_ready}, {31'b0, !mpending});
        step();
        @(negedge clk);
        chk("stream_done_single", {31'b0, stream_done}, 32'h0);
        step();
    endtask

    initial begin
        nrst         = 1'b0;
        clk_enable   = 1'b0;
        wr_en        = 1'b0;
        wr_addr      = '0;
        wr_dat       = '0;
        wr_commit    = 1'b0;
        column_ready = 1'b0;
        mfront       = 1'b0;
        mpending     = 1'b0;
        merr         = 1'b0;
        for (int b = 0; b < 2; b++)
            for (int k = 0; k < NW; k++) mdl[b][k] = '0;

        step();
        step();
        @(negedge clk);
        chk("rst_dat", {2'b0, framebuffer_dat}, 32'h0);
        chk("rst_wr_ready", {31'b0, wr_ready}, 32'h1);
        chk("rst_position_sync", {31'b0, position_sync}, 32'h0);
        chk("rst_stream_done", {31'b0, stream_done}, 32'h0);
        chk("rst_err", {31'b0, err_overrun}, 32'h0);
        nrst = 1'b1;
        step();

        // Identity column, commit, full-rate stream with swap.
        write_bank(1'b0);
        commit();
        @(negedge clk);
        chk("wr_ready_after_commit", {31'b0, wr_ready}, 32'h0);
        step();
        run_column(1, 1'b0, -1, -1);

        // Out-of-range write must not alias into the front bank; re-stream at 1/3 rate.
        write_word(10'd800, 30'h3fff_ffff);
        run_column(3, 1'b0, -1, -1);

        // New random bank, writes while wr_ready is low, double commit, stray request.
        write_bank(1'b1);
        commit();
        for (int k = 0; k < 10; k++) write_word(10'(k), 30'($urandom));
        commit();
        @(negedge clk);
        chk("err_after_double_commit", {31'b0, err_overrun}, 32'h1);
        chk("wr_ready_still_low", {31'b0, wr_ready}, 32'h0);
        step();
        run_column(1, 1'b0, 100, -1);

        // Reset at word 400, then restart from word 0 of the same front bank.
        run_column(1, 1'b0, -1, 400);
        run_column(1, 1'b0, -1, -1);

        // Commit and request in the same cycle.
        write_bank(1'b1);
        run_column(2, 1'b1, -1, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/column_buffer.md
COLUMN_BUFFER -- requirements
Module: column_buffer

Interface
REQ-001 SHALL have port clk, input, 1: sole clock, 66 MHz domain.
REQ-002 SHALL have port nrst, input, 1: reset, asynchronous, active-low.
REQ-003 SHALL have port clk_enable, input, 1: serial-slot strobe, the one driving the driver controller.
REQ-004 SHALL have port wr_en, input, 1: write strobe into back bank.
REQ-005 SHALL have port wr_addr, input, 10: word index 0..767 within back bank.
REQ-006 SHALL have port wr_dat, input, 30: one serial slot, bit i for driver i.
REQ-007 SHALL have port wr_commit, input, 1: one-cycle pulse; back bank complete.
REQ-008 SHALL have port wr_ready, output, 1: back bank free for writing.
REQ-009 SHALL have port column_ready, input, 1: one-cycle pulse from driver controller requesting the next column.
REQ-010 SHALL have port framebuffer_dat, output, 30: current serial slot to the driver controller.
REQ-011 SHALL have port position_sync, output, 1: one-cycle pulse on every bank swap.
REQ-012 SHALL have port stream_done, output, 1: one-cycle pulse after last word consumed.
REQ-013 SHALL have port err_overrun, output, 1: sticky; commit while pending, or column_ready while streaming.

Function
REQ-014 SHALL hold two banks (front/back) of 768 x 30-bit words; 768 = 16 LEDs x 48 bits.
REQ-015 SHALL route all writes to the back bank; wr_addr > 767 ignored; writes always accepted, even when wr_ready is low.
REQ-016 SHALL set commit_pending on wr_commit; wr_ready = not commit_pending.
REQ-017 SHALL on wr_commit while commit_pending: keep pending, set err_overrun.
REQ-018 SHALL implement FSM IDLE -> PREFETCH -> STREAM -> IDLE.
REQ-019 SHALL in IDLE on column_ready: if commit_pending, swap banks, clear pending, pulse position_sync same cycle as swap; else re-stream current front bank; go PREFETCH.
REQ-020 SHALL in PREFETCH issue read of word 0; word 0 on framebuffer_dat exactly 2 clk cycles after column_ready; enter STREAM.
REQ-021 SHALL in STREAM advance framebuffer_dat by one word per clk_enable-high cycle; hold while clk_enable low; keep a 1-word prefetch so no bubble.
REQ-022 SHALL after word 767 consumed: pulse stream_done, framebuffer_dat = 0, go IDLE.
REQ-023 SHALL ignore column_ready in PREFETCH/STREAM and set err_overrun.
REQ-024 SHALL on wr_commit and column_ready in the same IDLE cycle: commit takes effect first, so swap happens.
REQ-025 SHALL use a 10-bit read counter, terminal 767, no wrap past it.
REQ-026 SHALL output framebuffer_dat = 0 in IDLE.

Reset
REQ-027 SHALL on nrst low, asynchronously: FSM IDLE, front bank 0, commit_pending 0, wr_ready 1, framebuffer_dat 0, position_sync 0, stream_done 0, err_overrun 0, counters 0.
REQ-028 SHALL on reset mid-stream abort immediately; RAM contents not cleared; no stream_done.

Structure
REQ-029 SHALL place WORDS_PER_COLUMN (768), NB_DRIVERS (30), ADDR_W (10) and the FSM state enum in shared package column_buffer_pkg.
REQ-030 SHALL instantiate one sub-module column_ram: simple dual-port 1536 x 30, registered read, 1-cycle latency, bank bit as address MSB.

Verification
REQ-031 SHALL cover: write word k = k for k 0..767, commit, column_ready, clk_enable always 1 -> position_sync at swap; framebuffer_dat 0,1,...,767 on consecutive cycles from column_ready+2; stream_done after 767; wr_ready back to 1.
REQ-032 SHALL cover: clk_enable high 1 of 3 cycles -> each word held exactly 3 cycles, order unchanged.
REQ-033 SHALL cover: no commit before second column_ready -> same 768 words re-streamed, no position_sync.
REQ-034 SHALL cover: wr_commit twice without an intervening column_ready, and column_ready at word 100 -> err_overrun = 1 and stays 1; stream continues undisturbed.
REQ-035 SHALL cover: nrst low at word 400 -> framebuffer_dat 0, FSM IDLE next cycle; a later column_ready restarts at word 0 of the same front bank.
REQ-036 SHALL cover: wr_commit and column_ready in the same cycle -> swap and position_sync that cycle; streamed data from the newly committed bank.
